// File: rtl/lpc_cycle_framer.sv
// lpc_cycle_framer
//   Buffers decoded LPC I/O cycles in a small FIFO and serializes each one
//   into a fixed-length byte frame on a valid/ready byte stream. Cycles that
//   arrive while the FIFO is full (and nothing is popped that cycle) are
//   dropped, counted (saturating) and flagged in the next frame header.
//
//   Optional feature: define LPC_FRAMER_CHECKSUM_EN to append a fifth XOR
//   checksum byte (HDR ^ AH ^ AL ^ DAT) to every frame.
//
// Parameters
//   DEPTH     FIFO entries (power of two, 2..256)
//   SYNC_NIB  upper nibble of every header byte
// Ports
//   lpc_clk, lpc_reset_n         clock, asynchronous active-low reset
//   in_valid                     one-cycle strobe of a completed cycle
//   in_mode/in_direction         1 = I/O / 1 = write
//   in_addr[15:0], in_data[7:0]  cycle address and data
//   out_byte[7:0], out_valid     current frame byte and its qualifier
//   out_ready                    sink accepts out_byte this cycle
//   fifo_level                   FIFO occupancy (0..DEPTH)
//   drop_count[7:0]              dropped cycles since reset, saturating at 255
module lpc_cycle_framer #(
  parameter int          DEPTH    = 16,
  parameter logic [3:0]  SYNC_NIB = 4'hA
) (
  input  logic                     lpc_clk,
  input  logic                     lpc_reset_n,
  input  logic                     in_valid,
  input  logic                     in_mode,
  input  logic                     in_direction,
  input  logic [15:0]              in_addr,
  input  logic [7:0]               in_data,
  output logic [7:0]               out_byte,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_AH,
    S_AL,
    S_DAT
`ifdef LPC_FRAMER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [25:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    drop_q, drop_d;
  logic          ovf_q, ovf_d;
  // Shadow of the frame being sent: {ovf_snap, mode, direction, addr, data}
  logic [26:0]   sh_q, sh_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;

  logic          pop, push, drop, full, accept;
  logic [7:0]    hdr_b;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    accept  = valid_q && out_ready;

    case (state_q)
      S_IDLE: if (level_q != '0) begin
        pop     = 1'b1;
        state_d = S_HDR;
      end
      S_HDR:  if (accept) state_d = S_AH;
      S_AH:   if (accept) state_d = S_AL;
      S_AL:   if (accept) state_d = S_DAT;
`ifdef LPC_FRAMER_CHECKSUM_EN
      S_DAT:  if (accept) state_d = S_CHK;
      S_CHK:  if (accept) state_d = S_IDLE;
`else
      S_DAT:  if (accept) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase

    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // still succeeds when the serializer pops.
    full    = (level_q == LW'(DEPTH));
    push    = in_valid && (!full || pop);
    drop    = in_valid && full && !pop;

    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop  ? rd_q + 1'b1 : rd_q;
    level_d = level_q + LW'(push) - LW'(pop);
    drop_d  = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

    // A drop in the pop cycle must survive the clear.
    if (drop)     ovf_d = 1'b1;
    else if (pop) ovf_d = 1'b0;
    else          ovf_d = ovf_q;

    sh_d    = pop ? {ovf_q, mem_q[rd_q]} : sh_q;

    // Output byte is registered from the next state, so it is held
    // unchanged for as long as the state does not advance.
    hdr_b   = {SYNC_NIB, 1'b0, sh_d[26:24]};
    case (state_d)
      S_HDR:   byte_d = hdr_b;
      S_AH:    byte_d = sh_d[23:16];
      S_AL:    byte_d = sh_d[15:8];
      S_DAT:   byte_d = sh_d[7:0];
`ifdef LPC_FRAMER_CHECKSUM_EN
      S_CHK:   byte_d = hdr_b ^ sh_d[23:16] ^ sh_d[15:8] ^ sh_d[7:0];
`endif
      default: byte_d = 8'h00;
    endcase
    valid_d = (state_d != S_IDLE);
  end

  always_ff @(posedge lpc_clk or negedge lpc_reset_n) begin
    if (!lpc_reset_n) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
      sh_q    <= '0;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      sh_q    <= sh_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
    end
  end

  // FIFO storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge lpc_clk) begin
    if (push) mem_q[wr_q] <= {in_mode, in_direction, in_addr, in_data};
  end

  assign out_byte   = byte_q;
  assign out_valid  = valid_q;
  assign fifo_level = level_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_lpc_cycle_framer.sv
module tb_lpc_cycle_framer;

  localparam int DEPTH = 16;
`ifdef LPC_FRAMER_CHECKSUM_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  logic        lpc_clk = 1'b0;
  logic        lpc_reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_mode = 1'b0;
  logic        in_direction = 1'b0;
  logic [15:0] in_addr = '0;
  logic [7:0]  in_data = '0;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [7:0]  drop_count;

  lpc_cycle_framer #(.DEPTH(DEPTH), .SYNC_NIB(4'hA)) dut (
    .lpc_clk(lpc_clk), .lpc_reset_n(lpc_reset_n),
    .in_valid(in_valid), .in_mode(in_mode), .in_direction(in_direction),
    .in_addr(in_addr), .in_data(in_data),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .drop_count(drop_count)
  );

  always #5 lpc_clk = ~lpc_clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Pending cycles are a queue of entries; the frame in flight is a queue of
  // the bytes still to be delivered (front = byte on the wire).
  logic [25:0] mq[$];
  logic [7:0]  mcur[$];
  logic [7:0]  got[$];
  logic        mov = 1'b0;
  int          mdrop = 0;
  logic        prv_v = 1'b0;
  logic [7:0]  prv_b = 8'h00;
  logic        m_busy;
  logic [25:0] m_e;
  logic [7:0]  m_exp;

  function automatic void build(input logic [25:0] e, input logic ov);
    logic [7:0] h;
    h = {4'hA, 1'b0, ov, e[25], e[24]};
    mcur.push_back(h);
    mcur.push_back(e[23:16]);
    mcur.push_back(e[15:8]);
    mcur.push_back(e[7:0]);
`ifdef LPC_FRAMER_CHECKSUM_EN
    mcur.push_back(h ^ e[23:16] ^ e[15:8] ^ e[7:0]);
`endif
  endfunction

  always @(posedge lpc_clk or negedge lpc_reset_n) begin
    if (!lpc_reset_n) begin
      mq.delete();
      mcur.delete();
      mov   = 1'b0;
      mdrop = 0;
    end else begin
      if (prv_v && out_ready) got.push_back(prv_b);
      m_busy = (mcur.size() != 0);
      if (m_busy && out_ready) void'(mcur.pop_front());
      if (!m_busy && mq.size() != 0) begin
        m_e = mq.pop_front();
        build(m_e, mov);
        mov = 1'b0;
      end
      if (in_valid) begin
        if (mq.size() < DEPTH) mq.push_back({in_mode, in_direction, in_addr, in_data});
        else begin
          if (mdrop < 255) mdrop++;
          mov = 1'b1;
        end
      end
    end
    #1;
    m_exp = (mcur.size() != 0) ? mcur[0] : 8'h00;
    chk("m_out_valid", 32'(out_valid), 32'(mcur.size() != 0));
    chk("m_out_byte", 32'(out_byte), 32'(m_exp));
    chk("m_fifo_level", 32'(fifo_level), 32'(mq.size()));
    chk("m_drop_count", 32'(drop_count), 32'(mdrop));
    prv_v = out_valid;
    prv_b = out_byte;
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge lpc_clk);
  endtask

  task automatic push(input logic m, input logic d, input logic [15:0] a, input logic [7:0] x);
    in_mode = m; in_direction = d; in_addr = a; in_data = x;
    in_valid = 1'b1;
    @(negedge lpc_clk);
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    cyc(3);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_byte", 32'(out_byte), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_drop", 32'(drop_count), 0);
    lpc_reset_n = 1'b1;
    cyc(1);

    // Single cycle, sink always ready
    out_ready = 1'b1;
    got.delete();
    push(1'b1, 1'b1, 16'h0080, 8'h5A);
    chk("lat_level", 32'(fifo_level), 1);
    cyc(1);
    chk("lat_hdr_valid", 32'(out_valid), 1);
    chk("lat_hdr_byte", 32'(out_byte), 32'h A3);
    cyc(8);
    chk("single_len", 32'(got.size()), FL);
    if (got.size() >= 4) begin
      chk("single_b0", 32'(got[0]), 32'h A3);
      chk("single_b1", 32'(got[1]), 32'h 00);
      chk("single_b2", 32'(got[2]), 32'h 80);
      chk("single_b3", 32'(got[3]), 32'h 5A);
    end
`ifdef LPC_FRAMER_CHECKSUM_EN
    if (got.size() >= 5) chk("single_chk", 32'(got[4]), 32'h 79);
`endif
    chk("single_idle", 32'(out_valid), 0);

    // Backpressure in AL
    out_ready = 1'b0;
    got.delete();
    push(1'b0, 1'b0, 16'h1234, 8'hC3);
    cyc(1);
    out_ready = 1'b1;
    cyc(2);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_byte", 32'(out_byte), 32'h 34);
      chk("bp_valid", 32'(out_valid), 1);
      cyc(1);
    end
    out_ready = 1'b1;
    cyc(FL);
    chk("bp_len", 32'(got.size()), FL);
    if (got.size() >= 4) begin
      chk("bp_b0", 32'(got[0]), 32'h A0);
      chk("bp_b1", 32'(got[1]), 32'h 12);
      chk("bp_b2", 32'(got[2]), 32'h 34);
      chk("bp_b3", 32'(got[3]), 32'h C3);
    end
    cyc(3);

    // Overflow with a frame stalled in HDR
    out_ready = 1'b0;
    got.delete();
    push(1'b1, 1'b0, 16'hBEEF, 8'h01);
    cyc(1);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_mode = 1'b0; in_direction = 1'b1;
      in_addr = 16'(i); in_data = 8'(i + 16);
      @(negedge lpc_clk);
    end
    in_valid = 1'b0;
    chk("ovf_level", 32'(fifo_level), 16);
    chk("ovf_drop", 32'(drop_count), 4);

    // Push in the pop cycle of a full FIFO
    out_ready = 1'b1;
    for (int i = 0; i < 20 && out_valid; i++) cyc(1);
    chk("idle_reached", 32'(out_valid), 0);
    push(1'b1, 1'b1, 16'h7777, 8'h77);
    chk("full_pop_level", 32'(fifo_level), 16);
    chk("full_pop_drop", 32'(drop_count), 4);
    cyc(100);
    chk("drain_len", 32'(got.size()), 18 * FL);
    if (got.size() == 18 * FL) begin
      chk("hdr0_ovf", 32'(got[0][2]), 0);
      chk("hdr1_ovf", 32'(got[FL][2]), 1);
      chk("hdr2_ovf", 32'(got[2 * FL][2]), 0);
      chk("last_ah", 32'(got[17 * FL + 1]), 32'h 77);
    end
    chk("drain_level", 32'(fifo_level), 0);

    // Drop counter saturation
    out_ready = 1'b0;
    in_valid = 1'b1;
    cyc(320);
    in_valid = 1'b0;
    chk("sat_drop", 32'(drop_count), 255);
    chk("sat_level", 32'(fifo_level), 16);

    // Reset mid-frame
    lpc_reset_n = 1'b0;
    cyc(2);
    lpc_reset_n = 1'b1;
    cyc(1);
    for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 16'hAB00 + 16'(i), 8'(i));
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    chk("pre_rst_level", 32'(fifo_level), 3);
    chk("pre_rst_ah", 32'(out_byte), 32'h AB);
    #2 lpc_reset_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 0);
    chk("async_level", 32'(fifo_level), 0);
    chk("async_byte", 32'(out_byte), 0);
    cyc(2);
    lpc_reset_n = 1'b1;
    got.delete();
    out_ready = 1'b1;
    cyc(10);
    chk("post_rst_quiet", 32'(got.size()), 0);
    chk("post_rst_valid", 32'(out_valid), 0);
    push(1'b0, 1'b1, 16'h0102, 8'h03);
    cyc(8);
    chk("post_rst_len", 32'(got.size()), FL);
    if (got.size() >= 1) chk("post_rst_hdr", 32'(got[0]), 32'h A1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
